// File: rtl/pmem_pkg.sv
// Shared types and constants for the program-memory port arbiter.
// No logic of its own; the address-legality helper is pure combinational.
// No backpressure.
package pmem_pkg;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } pmem_state_t;

   localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
   localparam int unsigned DEPTH_WORDS_DEF = 256;

   // Word-aligned and inside the memory. The word index is compared instead of
   // the byte address, so 4*depth cannot overflow.
   function automatic logic addr_legal(input logic [31:0] addr, input int unsigned depth);
      return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
   endfunction

endpackage

// File: rtl/pmem_starve_timer.sv
// Saturating count of consecutive cycles in which a load was held off by fetch.
// One-cycle update; sat is a decode of the registered count.
// No backpressure; clr has priority over inc.
module pmem_starve_timer #(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic inc,
   output logic sat
);

   localparam int unsigned W = $clog2(MAX_WAIT + 1);

   logic [W-1:0] count;

   assign sat = (count == W'(MAX_WAIT));

   // Count stalled cycles; hold once saturated until cleared.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !sat) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pmem_port_arbiter.sv
// Shares the single-port program memory between fetch (read) and loader (write).
// Fetch data returns 1 cycle after accept; a load write happens in its grant cycle.
// Fetch wins in RUN; a load that has been starved MAX_WAIT cycles is forced through.
module pmem_port_arbiter
   import pmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
   parameter int unsigned MAX_WAIT    = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        boot_done,
   input  logic        boot_start,
   input  logic        fetch_req,
   input  logic [31:0] fetch_addr,
   output logic        fetch_ready,
   output logic        fetch_rvalid,
   output logic [31:0] fetch_rdata,
   output logic        fetch_err,
   input  logic        load_valid,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
   output logic        load_ready,
   output logic        load_err,
   output logic        boot_active,
   output logic [31:0] mem_byte_address,
   output logic        mem_write_enable,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   pmem_state_t state;
   logic        in_run;
   logic        starved;
   logic        fetch_acc;
   logic        load_hs;
   logic        starve_clr;
   logic        starve_inc;

   assign in_run = (state == RUN);

   // A starved load takes the port for one cycle and fetch is held off;
   // otherwise fetch always wins in RUN and the loader owns the port in BOOT.
   assign fetch_ready = in_run && !starved;
   assign load_ready  = !in_run || starved || !fetch_req;

   assign fetch_acc = fetch_req && fetch_ready;
   assign load_hs   = load_valid && load_ready;

   // Only a legal handshaken load writes; an illegal one still completes and
   // is flagged one cycle later. Reset blocks any write while it is asserted.
   assign mem_byte_address = load_hs ? load_addr : fetch_addr;
   assign mem_write_data   = load_data;
   assign mem_write_enable = reset_n && load_hs && addr_legal(load_addr, DEPTH_WORDS);

   // The count only means something while fetch competes with the loader in RUN.
   assign starve_clr = !in_run || boot_start || !load_valid || load_ready;
   assign starve_inc = in_run && load_valid && !load_ready;

   pmem_starve_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (starve_clr),
      .inc     (starve_inc),
      .sat     (starved)
   );

   // Boot FSM: boot_start in RUN beats a simultaneous boot_done.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= BOOT;
         boot_active <= 1'b1;
      end else begin
         case (state)
            BOOT: begin
               if (boot_done) begin
                  state       <= RUN;
                  boot_active <= 1'b0;
               end
            end
            RUN: begin
               if (boot_start) begin
                  state       <= BOOT;
                  boot_active <= 1'b1;
               end
            end
            default: begin
               state       <= BOOT;
               boot_active <= 1'b1;
            end
         endcase
      end
   end

   // Fetch response: capture memory data on accept, NOP plus error for a bad
   // address; data holds between responses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_rvalid <= 1'b0;
         fetch_rdata  <= NOP_INSTR;
         fetch_err    <= 1'b0;
      end else if (fetch_acc) begin
         fetch_rvalid <= 1'b1;
         if (addr_legal(fetch_addr, DEPTH_WORDS)) begin
            fetch_rdata <= mem_read_data;
            fetch_err   <= 1'b0;
         end else begin
            fetch_rdata <= NOP_INSTR;
            fetch_err   <= 1'b1;
         end
      end else begin
         fetch_rvalid <= 1'b0;
         fetch_err    <= 1'b0;
      end
   end

   // One-cycle pulse after a load that completed without writing.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         load_err <= 1'b0;
      end else begin
         load_err <= load_hs && !addr_legal(load_addr, DEPTH_WORDS);
      end
   end

endmodule

// File: tb/tb_pmem_port_arbiter.sv
// Directed bench for pmem_port_arbiter with a small behavioural program memory.
// Inputs change just after the falling edge; outputs are sampled before the next rise.
// Expected values are hand-computed constants.
module tb_pmem_port_arbiter;

   logic        clk;
   logic        reset_n;
   logic        boot_done;
   logic        boot_start;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_ready;
   logic        fetch_rvalid;
   logic [31:0] fetch_rdata;
   logic        fetch_err;
   logic        load_valid;
   logic [31:0] load_addr;
   logic [31:0] load_data;
   logic        load_ready;
   logic        load_err;
   logic        boot_active;
   logic [31:0] mem_byte_address;
   logic        mem_write_enable;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   logic [31:0] mem [256];

   int total = 0;
   int bad   = 0;

   pmem_port_arbiter dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .boot_done        (boot_done),
      .boot_start       (boot_start),
      .fetch_req        (fetch_req),
      .fetch_addr       (fetch_addr),
      .fetch_ready      (fetch_ready),
      .fetch_rvalid     (fetch_rvalid),
      .fetch_rdata      (fetch_rdata),
      .fetch_err        (fetch_err),
      .load_valid       (load_valid),
      .load_addr        (load_addr),
      .load_data        (load_data),
      .load_ready       (load_ready),
      .load_err         (load_err),
      .boot_active      (boot_active),
      .mem_byte_address (mem_byte_address),
      .mem_write_enable (mem_write_enable),
      .mem_write_data   (mem_write_data),
      .mem_read_data    (mem_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational-read program memory; out-of-range reads return a marker.
   always_comb begin
      mem_read_data = 32'hDEAD_BEEF;
      if (mem_byte_address < 32'd1024) mem_read_data = mem[mem_byte_address[9:2]];
   end

   always @(posedge clk) begin
      if (mem_write_enable && mem_byte_address < 32'd1024)
         mem[mem_byte_address[9:2]] <= mem_write_data;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      reset_n    = 1'b0;
      boot_done  = 1'b0;
      boot_start = 1'b0;
      fetch_req  = 1'b0;
      fetch_addr = 32'h0;
      load_valid = 1'b0;
      load_addr  = 32'h0;
      load_data  = 32'h0;

      // Reset state
      #12;
      check("rst_rvalid", {31'b0, fetch_rvalid}, 32'd0);
      check("rst_rdata", fetch_rdata, 32'h0000_0013);
      check("rst_ferr", {31'b0, fetch_err}, 32'd0);
      check("rst_lerr", {31'b0, load_err}, 32'd0);
      check("rst_boot", {31'b0, boot_active}, 32'd1);
      check("rst_we", {31'b0, mem_write_enable}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // BOOT: fetch is held off, loader owns the port
      @(negedge clk);
      fetch_req = 1'b1;
      #1;
      check("boot_fready", {31'b0, fetch_ready}, 32'd0);
      check("boot_lready", {31'b0, load_ready}, 32'd1);
      check("boot_active", {31'b0, boot_active}, 32'd1);

      // BOOT load 0x4 <- 0x00208193
      @(negedge clk);
      fetch_req  = 1'b0;
      load_valid = 1'b1;
      load_addr  = 32'h4;
      load_data  = 32'h0020_8193;
      #1;
      check("boot_we", {31'b0, mem_write_enable}, 32'd1);
      check("boot_waddr", mem_byte_address, 32'h4);
      @(negedge clk);
      load_valid = 1'b0;
      boot_done  = 1'b1;
      check("boot_lerr_ok", {31'b0, load_err}, 32'd0);
      @(negedge clk);
      boot_done = 1'b0;
      check("run_entered", {31'b0, boot_active}, 32'd0);

      // RUN fetch of the loaded word
      fetch_req  = 1'b1;
      fetch_addr = 32'h4;
      #1;
      check("run_fready", {31'b0, fetch_ready}, 32'd1);
      @(negedge clk);
      fetch_req = 1'b0;
      check("f4_rvalid", {31'b0, fetch_rvalid}, 32'd1);
      check("f4_rdata", fetch_rdata, 32'h0020_8193);
      check("f4_err", {31'b0, fetch_err}, 32'd0);
      @(negedge clk);
      check("idle_rvalid", {31'b0, fetch_rvalid}, 32'd0);
      check("idle_rdata_hold", fetch_rdata, 32'h0020_8193);

      // Starvation: load waits 4 cycles, forced on the 5th
      fetch_req  = 1'b1;
      fetch_addr = 32'h0;
      load_valid = 1'b1;
      load_addr  = 32'h8;
      load_data  = 32'h0000_0011;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("stall%0d_lready", i), {31'b0, load_ready}, 32'd0);
         check($sformatf("stall%0d_fready", i), {31'b0, fetch_ready}, 32'd1);
         @(negedge clk);
      end
      #1;
      check("force_lready", {31'b0, load_ready}, 32'd1);
      check("force_fready", {31'b0, fetch_ready}, 32'd0);
      check("force_we", {31'b0, mem_write_enable}, 32'd1);
      @(negedge clk);
      #1;
      check("after_lready", {31'b0, load_ready}, 32'd0);
      check("after_fready", {31'b0, fetch_ready}, 32'd1);
      check("force_mem", mem[2], 32'h0000_0011);
      @(negedge clk);
      fetch_req  = 1'b0;
      load_valid = 1'b0;

      // Illegal loads: misaligned and out of range
      @(negedge clk);
      load_valid = 1'b1;
      load_addr  = 32'h402;
      load_data  = 32'hFFFF_FFFF;
      #1;
      check("ill402_lready", {31'b0, load_ready}, 32'd1);
      check("ill402_we", {31'b0, mem_write_enable}, 32'd0);
      @(negedge clk);
      check("ill402_lerr", {31'b0, load_err}, 32'd1);
      load_addr = 32'h400;
      #1;
      check("ill400_we", {31'b0, mem_write_enable}, 32'd0);
      @(negedge clk);
      check("ill400_lerr", {31'b0, load_err}, 32'd1);
      load_valid = 1'b0;
      @(negedge clk);
      check("lerr_clear", {31'b0, load_err}, 32'd0);

      // Out-of-range fetch returns NOP with error
      fetch_req  = 1'b1;
      fetch_addr = 32'h400;
      @(negedge clk);
      fetch_req = 1'b0;
      check("f400_rvalid", {31'b0, fetch_rvalid}, 32'd1);
      check("f400_rdata", fetch_rdata, 32'h0000_0013);
      check("f400_err", {31'b0, fetch_err}, 32'd1);

      // Fetch accepted in the last RUN cycle still responds in BOOT
      @(negedge clk);
      fetch_req  = 1'b1;
      fetch_addr = 32'h4;
      boot_start = 1'b1;
      #1;
      check("bs_fready", {31'b0, fetch_ready}, 32'd1);
      @(negedge clk);
      boot_start = 1'b0;
      #1;
      check("bs_rvalid", {31'b0, fetch_rvalid}, 32'd1);
      check("bs_rdata", fetch_rdata, 32'h0020_8193);
      check("bs_boot", {31'b0, boot_active}, 32'd1);
      check("bs_fready_off", {31'b0, fetch_ready}, 32'd0);
      fetch_req = 1'b0;

      // boot_start while in BOOT is ignored; boot_done still enters RUN
      @(negedge clk);
      boot_start = 1'b1;
      boot_done  = 1'b1;
      @(negedge clk);
      boot_done = 1'b0;
      check("bs_in_boot_ignored", {31'b0, boot_active}, 32'd0);
      // boot_start and boot_done together in RUN: boot_start wins
      boot_done = 1'b1;
      @(negedge clk);
      boot_start = 1'b0;
      boot_done  = 1'b0;
      check("bs_wins", {31'b0, boot_active}, 32'd1);

      // Reset mid-fetch
      boot_done = 1'b1;
      @(negedge clk);
      boot_done  = 1'b0;
      fetch_req  = 1'b1;
      fetch_addr = 32'h4;
      @(posedge clk);
      #1;
      check("pre_rst_rvalid", {31'b0, fetch_rvalid}, 32'd1);
      fetch_req  = 1'b0;
      load_valid = 1'b1;
      load_addr  = 32'hC;
      load_data  = 32'h1234_5678;
      reset_n    = 1'b0;
      #1;
      check("mid_rst_rvalid", {31'b0, fetch_rvalid}, 32'd0);
      check("mid_rst_boot", {31'b0, boot_active}, 32'd1);
      check("mid_rst_we", {31'b0, mem_write_enable}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      check("mid_rst_nowrite", mem[3], 32'h0);
      load_valid = 1'b0;
      reset_n    = 1'b1;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
